// File: rtl/fpu_result_fifo.sv
// rtl/fpu_result_fifo.sv - first-word-fall-through result buffer for FPU results and status flags
//
// Buffers {result word, status flags} pairs produced by an FPU until a
// consumer takes them, and keeps sticky records of flags and drops.
//
// Ports:
//   clk           in   sole clock, rising edge
//   reset         in   asynchronous active-high reset
//   res_valid_in  in   FPU result present this cycle
//   data_in       in   [31:0] result word
//   status_in     in   [3:0] flags: [0] EXACT [1] OVERFLOW [2] UNDERFLOW [3] INEXACT
//   res_ready_out out  FIFO not full
//   out_valid     out  head entry available
//   out_ready     in   consumer accepts head this cycle
//   data_out      out  [31:0] head result word (0 while empty)
//   status_out    out  [3:0] head flags (0 while empty)
//   count_out     out  occupancy 0..DEPTH
//   sticky_flags  out  OR of status of accepted results since last clear
//   clear_sticky  in   synchronous clear of sticky_flags
//   drop_err      out  set when a result is offered while full; held until reset

module fpu_result_fifo #(
    parameter int DEPTH = 4  // power of two, >= 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       res_valid_in,
    input  logic [31:0]                data_in,
    input  logic [3:0]                 status_in,
    output logic                       res_ready_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                data_out,
    output logic [3:0]                 status_out,
    output logic [$clog2(DEPTH):0]     count_out,
    output logic [3:0]                 sticky_flags,
    input  logic                       clear_sticky,
    output logic                       drop_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Storage is not reset; the head is masked while empty instead.
    logic [35:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [3:0]    sticky;
    logic          drop;

    logic full;
    logic push;
    logic pop;
    logic [35:0] head;

    assign full = (count == FULL_COUNT);
    // A pop in the same cycle does not free a slot for the offered result.
    assign push = res_valid_in && !full;
    assign pop  = out_valid && out_ready;

    assign res_ready_out = !full;
    assign out_valid     = (count != '0);
    assign count_out     = count;
    assign sticky_flags  = sticky;
    assign drop_err      = drop;

    assign head       = out_valid ? mem[rd_ptr] : 36'h0;
    assign data_out   = head[35:4];
    assign status_out = head[3:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            sticky <= 4'b0000;
            drop   <= 1'b0;
        end else begin
            // Pointer width equals log2(DEPTH), so the increment wraps naturally.
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // Clear wins over history but not over the flags of a coincident push.
            if (clear_sticky) begin
                sticky <= push ? status_in : 4'b0000;
            end else if (push) begin
                sticky <= sticky | status_in;
            end

            if (res_valid_in && full) begin
                drop <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {data_in, status_in};
        end
    end

endmodule

// File: tb/tb_fpu_result_fifo.sv
// tb/tb_fpu_result_fifo.sv - self-checking bench for fpu_result_fifo against a queue model

module tb_fpu_result_fifo;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        res_valid_in = 1'b0;
    logic [31:0] data_in = '0;
    logic [3:0]  status_in = '0;
    logic        res_ready_out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] data_out;
    logic [3:0]  status_out;
    logic [2:0]  count_out;
    logic [3:0]  sticky_flags;
    logic        clear_sticky = 1'b0;
    logic        drop_err;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of {word, flags} plus sticky state.
    logic [35:0] m_q[$];
    logic [3:0]  m_sticky = 4'b0;
    logic        m_drop = 1'b0;

    fpu_result_fifo #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .res_valid_in (res_valid_in),
        .data_in      (data_in),
        .status_in    (status_in),
        .res_ready_out(res_ready_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_out     (data_out),
        .status_out   (status_out),
        .count_out    (count_out),
        .sticky_flags (sticky_flags),
        .clear_sticky (clear_sticky),
        .drop_err     (drop_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic set_in(input logic v, input logic [31:0] d, input logic [3:0] s,
                          input logic r, input logic c);
        res_valid_in = v;
        data_in      = d;
        status_in    = s;
        out_ready    = r;
        clear_sticky = c;
    endtask

    // One clock: model follows the same inputs the DUT samples; return at negedge.
    task automatic tick();
        bit accept;
        @(posedge clk);
        accept = res_valid_in && (m_q.size() < DEPTH);
        if (res_valid_in && m_q.size() == DEPTH) m_drop = 1'b1;
        if (out_ready && m_q.size() != 0) void'(m_q.pop_front());
        if (accept) m_q.push_back({data_in, status_in});
        if (clear_sticky) m_sticky = accept ? status_in : 4'b0;
        else if (accept)  m_sticky = m_sticky | status_in;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (count_out !== 3'd0 || out_valid !== 1'b0 || res_ready_out !== 1'b1 ||
            sticky_flags !== 4'b0 || drop_err !== 1'b0 || data_out !== 32'h0 || status_out !== 4'h0) begin
            errors++;
            $display("FAIL reset_state got cnt=%0d v=%b rdy=%b st=%b drop=%b d=%h s=%b exp 0 0 1 0000 0 0 0",
                     count_out, out_valid, res_ready_out, sticky_flags, drop_err, data_out, status_out);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        set_in(1, 32'h4D5D1148, 4'b1000, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 32'h4D5D1148 || status_out !== 4'b1000 ||
            count_out !== 3'd1 || sticky_flags !== 4'b1000) begin
            errors++;
            $display("FAIL single_entry got v=%b d=%h s=%b cnt=%0d st=%b exp 1 4d5d1148 1000 1 1000",
                     out_valid, data_out, status_out, count_out, sticky_flags);
        end
        set_in(0, 0, 0, 1, 0);
        tick();
        checks++;
        if (out_valid !== 1'b0 || count_out !== 3'd0 || data_out !== 32'h0 || status_out !== 4'h0) begin
            errors++;
            $display("FAIL single_drain got v=%b cnt=%0d d=%h s=%b exp 0 0 0 0",
                     out_valid, count_out, data_out, status_out);
        end
    endtask

    task automatic test_fill_overflow();
        logic [31:0] words [4] = '{32'h40000000, 32'h7F800000, 32'h00000000, 32'h3F800000};
        logic [3:0]  flags [4] = '{4'b0001, 4'b1010, 4'b0100, 4'b0001};
        set_in(0, 0, 0, 0, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(1, words[i], flags[i], 0, 0);
            tick();
        end
        set_in(1, 32'h12345678, 4'b0000, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        checks++;
        if (count_out !== 3'd4 || res_ready_out !== 1'b0 || drop_err !== 1'b1 || sticky_flags !== 4'b1111) begin
            errors++;
            $display("FAIL overflow got cnt=%0d rdy=%b drop=%b st=%b exp 4 0 1 1111",
                     count_out, res_ready_out, drop_err, sticky_flags);
        end
        // Offer while full with a pop in the same cycle: offer is still dropped.
        set_in(1, 32'hDEADBEEF, 4'b1111, 1, 0);
        tick();
        set_in(0, 0, 0, 1, 0);
        checks++;
        if (count_out !== 3'd3 || sticky_flags !== 4'b1111) begin
            errors++;
            $display("FAIL full_pop_drop got cnt=%0d st=%b exp 3 1111", count_out, sticky_flags);
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || data_out !== words[i] || status_out !== flags[i]) begin
                errors++;
                $display("FAIL drain_order[%0d] got v=%b d=%h s=%b exp 1 %h %b",
                         i, out_valid, data_out, status_out, words[i], flags[i]);
            end
            tick();
        end
        set_in(0, 0, 0, 0, 0);
        checks++;
        if (out_valid !== 1'b0 || count_out !== 3'd0) begin
            errors++;
            $display("FAIL drain_empty got v=%b cnt=%0d exp 0 0", out_valid, count_out);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            set_in(1, $urandom, 4'($urandom), 0, 0);
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            set_in(1, $urandom, 4'($urandom), 1, 0);
            checks++;
            if (data_out !== m_q[0][35:4] || status_out !== m_q[0][3:0]) begin
                errors++;
                $display("FAIL b2b_head[%0d] got %h/%b exp %h/%b", i, data_out, status_out,
                         m_q[0][35:4], m_q[0][3:0]);
            end
            tick();
            checks++;
            if (count_out !== 3'd2) begin
                errors++;
                $display("FAIL b2b_count[%0d] got %0d exp 2", i, count_out);
            end
        end
        for (int i = 0; i < 2; i++) begin
            set_in(0, 0, 0, 1, 0);
            checks++;
            if (out_valid !== 1'b1 || data_out !== m_q[0][35:4] || status_out !== m_q[0][3:0]) begin
                errors++;
                $display("FAIL b2b_drain[%0d] got %b %h/%b exp 1 %h/%b", i, out_valid, data_out,
                         status_out, m_q[0][35:4], m_q[0][3:0]);
            end
            tick();
        end
        set_in(0, 0, 0, 0, 0);
    endtask

    task automatic test_sticky_clear();
        set_in(0, 0, 0, 0, 1);
        tick();
        set_in(1, 32'h11111111, 4'b1010, 0, 0);
        tick();
        checks++;
        if (sticky_flags !== 4'b1010) begin
            errors++;
            $display("FAIL sticky_set got %b exp 1010", sticky_flags);
        end
        set_in(1, 32'h22222222, 4'b0001, 0, 1);
        tick();
        set_in(0, 0, 0, 0, 0);
        checks++;
        if (sticky_flags !== 4'b0001 || drop_err !== 1'b1) begin
            errors++;
            $display("FAIL sticky_clear_push got st=%b drop=%b exp 0001 1", sticky_flags, drop_err);
        end
        set_in(0, 0, 0, 1, 1);
        tick();
        tick();
        set_in(0, 0, 0, 0, 0);
        checks++;
        if (sticky_flags !== 4'b0000 || count_out !== 3'd0) begin
            errors++;
            $display("FAIL sticky_clear got st=%b cnt=%0d exp 0000 0", sticky_flags, count_out);
        end
    endtask

    task automatic test_empty_pop();
        set_in(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || count_out !== 3'd0) begin
                errors++;
                $display("FAIL empty_pop[%0d] got v=%b cnt=%0d exp 0 0", i, out_valid, count_out);
            end
        end
        set_in(1, 32'hCAFEF00D, 4'b1001, 1, 0);
        tick();
        set_in(0, 0, 0, 1, 0);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 32'hCAFEF00D || status_out !== 4'b1001 || count_out !== 3'd1) begin
            errors++;
            $display("FAIL empty_pop_push got v=%b d=%h s=%b cnt=%0d exp 1 cafef00d 1001 1",
                     out_valid, data_out, status_out, count_out);
        end
        tick();
        set_in(0, 0, 0, 0, 0);
        checks++;
        if (out_valid !== 1'b0 || count_out !== 3'd0) begin
            errors++;
            $display("FAIL empty_pop_once got v=%b cnt=%0d exp 0 0", out_valid, count_out);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1, $urandom, 4'($urandom), 0, 0);
            tick();
        end
        set_in(0, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (count_out !== 3'd0 || out_valid !== 1'b0 || res_ready_out !== 1'b1 || sticky_flags !== 4'b0 ||
            drop_err !== 1'b0 || data_out !== 32'h0 || status_out !== 4'h0) begin
            errors++;
            $display("FAIL async_reset got cnt=%0d v=%b rdy=%b st=%b drop=%b d=%h exp 0 0 1 0000 0 0",
                     count_out, out_valid, res_ready_out, sticky_flags, drop_err, data_out);
        end
        m_q.delete();
        m_sticky = 4'b0;
        m_drop   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || count_out !== 3'd0) begin
            errors++;
            $display("FAIL after_release got v=%b cnt=%0d exp 0 0", out_valid, count_out);
        end
        set_in(1, 32'h3F000000, 4'b0001, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        checks++;
        if (count_out !== 3'd1 || data_out !== 32'h3F000000 || status_out !== 4'b0001) begin
            errors++;
            $display("FAIL first_push got cnt=%0d d=%h s=%b exp 1 3f000000 0001",
                     count_out, data_out, status_out);
        end
    endtask

    task automatic test_random();
        logic [35:0] exp_head;
        int push_pct;
        int pop_pct;
        for (int c = 0; c < 600; c++) begin
            push_pct = (c < 200) ? 80 : (c < 400) ? 50 : 20;
            pop_pct  = (c < 200) ? 25 : (c < 400) ? 50 : 80;
            set_in(($urandom_range(99) < push_pct), $urandom, 4'($urandom),
                   ($urandom_range(99) < pop_pct), ($urandom_range(99) < 8));
            tick();
            exp_head = (m_q.size() != 0) ? m_q[0] : 36'h0;
            checks++;
            if (data_out !== exp_head[35:4] || status_out !== exp_head[3:0]) begin
                errors++;
                $display("FAIL rand_head cyc %0d got %h/%b exp %h/%b", c, data_out, status_out,
                         exp_head[35:4], exp_head[3:0]);
            end
            checks++;
            if (count_out !== 3'(m_q.size()) || out_valid !== (m_q.size() != 0) ||
                res_ready_out !== (m_q.size() != DEPTH)) begin
                errors++;
                $display("FAIL rand_count cyc %0d got cnt=%0d v=%b rdy=%b exp cnt=%0d",
                         c, count_out, out_valid, res_ready_out, m_q.size());
            end
            checks++;
            if (sticky_flags !== m_sticky || drop_err !== m_drop) begin
                errors++;
                $display("FAIL rand_sticky cyc %0d got st=%b drop=%b exp st=%b drop=%b",
                         c, sticky_flags, drop_err, m_sticky, m_drop);
            end
        end
        set_in(0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_back_to_back();
        test_sticky_clear();
        test_empty_pop();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
